// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS/CTRL bit positions, FSM encoding and the
// default bit divisor.
package uart_tx_pkg;

    // Register offsets (decoded from Addr[3:2])
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // STATUS bit positions
    localparam int STAT_BUSY  = 0;
    localparam int STAT_READY = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    // CTRL bit positions
    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;

    // Cycles per bit after reset (115200 baud from 50 MHz)
    localparam logic [15:0] DIV_DEFAULT = 16'd434;

    // Queue depth when the FIFO build is selected
    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } txState_t;

    // A divisor of zero would never expire; run it as one cycle per bit.
    function automatic logic [15:0] effectiveDiv(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_tx_dev_if.sv
// Peripheral bus seen by the UART: word address, write strobe, write
// data and combinational read data. The bridge is the master.
interface uart_tx_dev_if;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (output Addr, output WE, output Din, input Dout);
    modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue for the UART.
// UART_TX_FIFO_EN defined: DEPTH-entry circular queue, pointers carry
// one extra bit to tell full from empty.
// UART_TX_FIFO_EN undefined: a single holding register; DEPTH unused.
// A push is accepted when the queue is not full, or when a pop happens
// on the same edge. The head is read combinationally so the FSM can
// load it on the very edge it decides to pop.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    logic pushOk;

`ifdef UART_TX_FIFO_EN

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wrPtrReg;
    logic [AW:0] rdPtrReg;

    assign pushOk = push && (!full || pop);
    assign empty  = (wrPtrReg == rdPtrReg);
    assign full   = (wrPtrReg[AW] != rdPtrReg[AW]) &&
                    (wrPtrReg[AW-1:0] == rdPtrReg[AW-1:0]);
    assign head   = mem[rdPtrReg[AW-1:0]];

    // Storage write; contents need no reset since empty gates every read
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtrReg[AW-1:0]] <= din;
        end
    end

    // Read/write pointers, wrapping naturally modulo 2*DEPTH
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
        end else begin
            if (pushOk) begin
                wrPtrReg <= wrPtrReg + {{AW{1'b0}}, 1'b1};
            end
            if (pop && !empty) begin
                rdPtrReg <= rdPtrReg + {{AW{1'b0}}, 1'b1};
            end
        end
    end

`else

    localparam int unusedDepth = DEPTH;

    logic       validReg;
    logic [7:0] dataReg;

    assign pushOk = push && (!validReg || pop);
    assign full   = validReg;
    assign empty  = !validReg;
    assign head   = dataReg;

    // Single holding register; a same-edge pop frees it for the new byte
    always_ff @(posedge clk) begin
        if (!reset) begin
            validReg <= 1'b0;
            dataReg  <= 8'd0;
        end else if (pushOk) begin
            validReg <= 1'b1;
            dataReg  <= din;
        end else if (pop) begin
            validReg <= 1'b0;
        end
    end

`endif

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter on the CPU peripheral bus.
// Registers at Addr[3:2]: DATA (push), STATUS, DIVISOR, CTRL (EN, IE).
// Queued bytes are shifted out LSB first on txd; IRQ is raised while
// IE is set, the queue is empty and the transmitter is idle.
// Build option: UART_TX_FIFO_EN selects a FIFO_DEPTH-entry queue instead
// of the single holding register.
module uart_tx_dev
    import uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter logic [15:0] DIV_RESET  = DIV_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_dev_if.slave bus,
    output logic         IRQ,
    output logic         txd
);

    // Register file
    logic [15:0] divisorReg;
    logic        enReg;
    logic        ieReg;
    logic        ovfReg;

    // Transmit datapath / FSM state
    txState_t    stateReg;
    logic [15:0] baudCntReg;
    logic [15:0] frameDivReg;
    logic [2:0]  bitCntReg;
    logic [7:0]  shiftReg;
    logic        txdReg;

    // Queue interface
    logic       fifoFull;
    logic       fifoEmpty;
    logic [7:0] fifoHead;

    // Bus decode
    logic [1:0] regSel;
    logic       wrData;
    logic       wrStatus;
    logic       wrDivisor;
    logic       wrCtrl;

    // Control
    logic        baudDone;
    logic        popReq;
    logic        busy;
    logic [15:0] loadDiv;
    logic [31:0] statusWord;
    logic        unusedBits;

    assign regSel    = bus.Addr[3:2];
    assign wrData    = bus.WE && (regSel == REG_DATA);
    assign wrStatus  = bus.WE && (regSel == REG_STATUS);
    assign wrDivisor = bus.WE && (regSel == REG_DIVISOR);
    assign wrCtrl    = bus.WE && (regSel == REG_CTRL);

    assign unusedBits = &{1'b0, bus.Addr[29:4], bus.Addr[1:0], bus.Din[31:16]};

    assign baudDone = (baudCntReg == 16'd0);
    assign busy     = (stateReg != ST_IDLE);
    assign loadDiv  = effectiveDiv(divisorReg);

    // A new frame starts from idle, or straight out of a finished stop bit
    assign popReq = !fifoEmpty && enReg &&
                    ((stateReg == ST_IDLE) || ((stateReg == ST_STOP) && baudDone));

    assign txd = txdReg;
    assign IRQ = ieReg && fifoEmpty && !busy;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wrData),
        .pop   (popReq),
        .din   (bus.Din[7:0]),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .head  (fifoHead)
    );

    // Software-visible registers and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            divisorReg <= DIV_RESET;
            enReg      <= 1'b0;
            ieReg      <= 1'b0;
            ovfReg     <= 1'b0;
        end else begin
            if (wrDivisor) begin
                divisorReg <= bus.Din[15:0];
            end
            if (wrCtrl) begin
                enReg <= bus.Din[CTRL_EN];
                ieReg <= bus.Din[CTRL_IE];
            end
            if (wrStatus) begin
                ovfReg <= 1'b0;
            end else if (wrData && fifoFull && !popReq) begin
                ovfReg <= 1'b1;
            end
        end
    end

    // Frame FSM: start bit, eight data bits LSB first, stop bit
    always_ff @(posedge clk) begin
        if (!reset) begin
            stateReg    <= ST_IDLE;
            txdReg      <= 1'b1;
            baudCntReg  <= 16'd0;
            frameDivReg <= 16'd1;
            bitCntReg   <= 3'd0;
            shiftReg    <= 8'd0;
        end else begin
            case (stateReg)
                ST_IDLE: begin
                    if (popReq) begin
                        stateReg    <= ST_START;
                        txdReg      <= 1'b0;
                        shiftReg    <= fifoHead;
                        frameDivReg <= loadDiv;
                        baudCntReg  <= loadDiv - 16'd1;
                    end
                end
                ST_START: begin
                    if (baudDone) begin
                        stateReg   <= ST_DATA;
                        txdReg     <= shiftReg[0];
                        bitCntReg  <= 3'd0;
                        baudCntReg <= frameDivReg - 16'd1;
                    end else begin
                        baudCntReg <= baudCntReg - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baudDone) begin
                        baudCntReg <= frameDivReg - 16'd1;
                        if (bitCntReg == 3'd7) begin
                            stateReg <= ST_STOP;
                            txdReg   <= 1'b1;
                        end else begin
                            bitCntReg <= bitCntReg + 3'd1;
                            shiftReg  <= shiftReg >> 1;
                            txdReg    <= shiftReg[1];
                        end
                    end else begin
                        baudCntReg <= baudCntReg - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baudDone) begin
                        if (popReq) begin
                            stateReg    <= ST_START;
                            txdReg      <= 1'b0;
                            shiftReg    <= fifoHead;
                            frameDivReg <= loadDiv;
                            baudCntReg  <= loadDiv - 16'd1;
                        end else begin
                            stateReg <= ST_IDLE;
                        end
                    end else begin
                        baudCntReg <= baudCntReg - 16'd1;
                    end
                end
                default: begin
                    stateReg <= ST_IDLE;
                    txdReg   <= 1'b1;
                end
            endcase
        end
    end

    // STATUS word assembled from live state
    always_comb begin
        statusWord             = 32'd0;
        statusWord[STAT_BUSY]  = busy;
        statusWord[STAT_READY] = !fifoFull;
        statusWord[STAT_EMPTY] = fifoEmpty;
        statusWord[STAT_OVF]   = ovfReg;
    end

    // Combinational read mux for the addressed register
    always_comb begin
        bus.Dout = 32'd0;
        case (regSel)
            REG_DATA:    bus.Dout = 32'd0;
            REG_STATUS:  bus.Dout = statusWord;
            REG_DIVISOR: bus.Dout = {16'd0, divisorReg};
            REG_CTRL:    bus.Dout = {30'd0, ieReg, enReg};
            default:     bus.Dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Testbench for uart_tx_dev. A frame-level reference model (byte queue,
// frame start edge, bit index = elapsed cycles / divisor) predicts txd,
// IRQ and STATUS after every clock edge.
module tb_uart_tx_dev;

`ifdef UART_TX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_STAT = 2'd1;
    localparam logic [1:0] A_DIV  = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    logic clk;
    logic reset;
    logic IRQ;
    logic txd;

    uart_tx_dev_if bus();

    uart_tx_dev dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .IRQ   (IRQ),
        .txd   (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecCount = 0;
    int errCount = 0;

    // Reference model state
    logic [7:0]  mQ[$];
    bit          mOvf = 0;
    bit          mEn = 0;
    bit          mIe = 0;
    logic [15:0] mDiv = 16'd434;
    bit          mActive = 0;
    logic [9:0]  mBits = 10'h3ff;
    int          mFrameDiv = 1;
    longint      mStart = 0;
    longint      mEdge = 0;

    task automatic modelEdge(input bit w, input logic [1:0] a, input logic [31:0] d, input bit r);
        bit ended;
        bit popNow;
        logic [7:0] b;
        mEdge++;
        if (!r) begin
            mQ.delete();
            mOvf = 0; mEn = 0; mIe = 0; mDiv = 16'd434; mActive = 0;
            return;
        end
        ended  = mActive && ((mEdge - mStart) == longint'(10 * mFrameDiv));
        popNow = (!mActive || ended) && (mQ.size() > 0) && mEn;
        if (popNow) begin
            b = mQ.pop_front();
            mBits = {1'b1, b, 1'b0};
            mStart = mEdge;
            mFrameDiv = (mDiv == 16'd0) ? 1 : int'(mDiv);
            mActive = 1;
        end else if (ended) begin
            mActive = 0;
        end
        if (w) begin
            case (a)
                A_DATA: if (mQ.size() < CAP) mQ.push_back(d[7:0]); else mOvf = 1;
                A_STAT: mOvf = 0;
                A_DIV:  mDiv = d[15:0];
                A_CTRL: begin mEn = d[0]; mIe = d[1]; end
                default: ;
            endcase
        end
    endtask

    function automatic logic expTxd();
        int idx;
        if (!mActive) return 1'b1;
        idx = int'((mEdge - mStart) / longint'(mFrameDiv));
        return mBits[idx];
    endfunction

    function automatic logic expIrq();
        return mIe && (mQ.size() == 0) && !mActive;
    endfunction

    function automatic logic [31:0] expStatus();
        return {28'd0, mOvf, (mQ.size() == 0), (mQ.size() < CAP), mActive};
    endfunction

    // One clock: drive bus/reset, update the model at the edge, then park
    // Addr on STATUS so Dout can be sampled after the edge.
    task automatic tick(input bit w, input logic [1:0] a, input logic [31:0] d, input bit r);
        bus.WE = w; bus.Addr = {26'd0, a, 2'd0}; bus.Din = d; reset = r;
        @(posedge clk);
        modelEdge(w, a, d, r);
        #1;
        if (w) $display("[%0t] write reg %0d data=%h", $time, a, d);
        if (!r) $display("[%0t] reset pulse", $time);
        bus.WE = 1'b0; reset = 1'b1; bus.Addr = {26'd0, A_STAT, 2'd0};
        #1;
    endtask

    task automatic readReg(input logic [1:0] a, output logic [31:0] v);
        bus.Addr = {26'd0, a, 2'd0};
        #1;
        v = bus.Dout;
        bus.Addr = {26'd0, A_STAT, 2'd0};
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        tick(0, A_DATA, 0, 0);
        tick(0, A_DATA, 0, 0);
        tick(0, A_DATA, 0, 1);
        vecCount++;
        if (txd !== 1'b1) begin errCount++; $display("FAIL reset_txd: got %b want 1", txd); end
        vecCount++;
        if (IRQ !== 1'b0) begin errCount++; $display("FAIL reset_irq: got %b want 0", IRQ); end
        readReg(A_STAT, v);
        vecCount++;
        if (v !== 32'h6) begin errCount++; $display("FAIL reset_status: got %h want 00000006", v); end
        readReg(A_DIV, v);
        vecCount++;
        if (v !== 32'd434) begin errCount++; $display("FAIL reset_divisor: got %0d want 434", v); end
        readReg(A_CTRL, v);
        vecCount++;
        if (v !== 32'd0) begin errCount++; $display("FAIL reset_ctrl: got %h want 0", v); end
    endtask

    task automatic test_frame();
        int busyCycles = 0;
        tick(1, A_DIV, 32'd4, 1);
        tick(1, A_CTRL, 32'd1, 1);
        tick(1, A_DATA, 32'hA5, 1);
        vecCount++;
        if (txd !== 1'b1) begin errCount++; $display("FAIL frame_push_edge: txd=%b want 1", txd); end
        for (int i = 0; i < 44; i++) begin
            tick(0, A_DATA, 0, 1);
            if (bus.Dout[0] === 1'b1) busyCycles++;
            vecCount++;
            if (txd !== expTxd() || bus.Dout !== expStatus()) begin
                errCount++;
                $display("FAIL frame cyc %0d: txd=%b status=%h want txd=%b status=%h",
                         i, txd, bus.Dout, expTxd(), expStatus());
            end
        end
        vecCount++;
        if (busyCycles != 40) begin errCount++; $display("FAIL frame_busy_len: got %0d want 40", busyCycles); end
    endtask

    task automatic test_irq();
        tick(1, A_CTRL, 32'd3, 1);
        vecCount++;
        if (IRQ !== 1'b1) begin errCount++; $display("FAIL irq_idle: got %b want 1", IRQ); end
        tick(1, A_DATA, 32'h55, 1);
        for (int i = 0; i < 44; i++) begin
            tick(0, A_DATA, 0, 1);
            vecCount++;
            if (IRQ !== expIrq() || txd !== expTxd()) begin
                errCount++;
                $display("FAIL irq cyc %0d: IRQ=%b txd=%b want IRQ=%b txd=%b", i, IRQ, txd, expIrq(), expTxd());
            end
        end
        vecCount++;
        if (IRQ !== 1'b1) begin errCount++; $display("FAIL irq_drained: got %b want 1", IRQ); end
    endtask

    task automatic test_overflow();
        int div;
        int busyCycles = 0;
        tick(1, A_CTRL, 32'd0, 1);
        for (int i = 0; i <= CAP; i++) tick(1, A_DATA, 32'($urandom_range(0, 255)), 1);
        vecCount++;
        if (bus.Dout !== expStatus() || bus.Dout[3] !== 1'b1 || bus.Dout[1] !== 1'b0) begin
            errCount++; $display("FAIL ovf_status: got %h want %h (ovf=1 ready=0)", bus.Dout, expStatus());
        end
        div = int'($urandom_range(1, 3));
        tick(1, A_DIV, 32'(div), 1);
        tick(1, A_CTRL, 32'd1, 1);
        for (int i = 0; i < CAP * 10 * div + 6; i++) begin
            tick(0, A_DATA, 0, 1);
            if (bus.Dout[0] === 1'b1) busyCycles++;
            vecCount++;
            if (txd !== expTxd() || bus.Dout !== expStatus()) begin
                errCount++;
                $display("FAIL ovf_drain cyc %0d: txd=%b status=%h want txd=%b status=%h",
                         i, txd, bus.Dout, expTxd(), expStatus());
            end
        end
        vecCount++;
        if (busyCycles != CAP * 10 * div) begin
            errCount++; $display("FAIL ovf_no_gap: busy %0d want %0d", busyCycles, CAP * 10 * div);
        end
        tick(1, A_STAT, 32'd0, 1);
        vecCount++;
        if (bus.Dout[3] !== 1'b0) begin errCount++; $display("FAIL ovf_clear: ovf=%b want 0", bus.Dout[3]); end
    endtask

    task automatic test_back_to_back();
        tick(1, A_DIV, 32'd2, 1);
        tick(1, A_CTRL, 32'd1, 1);
        tick(1, A_DATA, 32'h11, 1);
        tick(1, A_DATA, 32'h22, 1);
        for (int i = 0; i < 70; i++) begin
            if (i == 5) tick(1, A_DATA, 32'($urandom_range(0, 255)), 1);
            else        tick(0, A_DATA, 0, 1);
            vecCount++;
            if (txd !== expTxd() || bus.Dout !== expStatus()) begin
                errCount++;
                $display("FAIL b2b cyc %0d: txd=%b status=%h want txd=%b status=%h",
                         i, txd, bus.Dout, expTxd(), expStatus());
            end
        end
    endtask

    task automatic test_reset_midframe();
        tick(1, A_STAT, 32'd0, 1);
        tick(1, A_DIV, 32'd3, 1);
        tick(1, A_CTRL, 32'd1, 1);
        tick(1, A_DATA, 32'($urandom_range(0, 255)), 1);
        for (int i = 0; i < 13; i++) begin
            tick(0, A_DATA, 0, 1);
            vecCount++;
            if (txd !== expTxd()) begin errCount++; $display("FAIL rst_pre cyc %0d: txd=%b want %b", i, txd, expTxd()); end
        end
        tick(0, A_DATA, 0, 0);
        vecCount++;
        if (txd !== 1'b1 || bus.Dout !== 32'h6) begin
            errCount++; $display("FAIL rst_mid: txd=%b status=%h want txd=1 status=00000006", txd, bus.Dout);
        end
        for (int i = 0; i < 40; i++) begin
            tick(0, A_DATA, 0, 1);
            vecCount++;
            if (txd !== 1'b1 || bus.Dout !== 32'h6) begin
                errCount++; $display("FAIL rst_post cyc %0d: txd=%b status=%h want txd=1 status=00000006", i, txd, bus.Dout);
            end
        end
    endtask

    task automatic test_random();
        int r;
        tick(1, A_DIV, 32'd1, 1);
        tick(1, A_CTRL, 32'd3, 1);
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 12)      tick(1, A_DATA, 32'($urandom), 1);
            else if (r < 15) tick(1, A_DIV, 32'($urandom_range(0, 3)), 1);
            else if (r < 18) tick(1, A_CTRL, ($urandom_range(0, 3) == 0) ? 32'd2 : 32'd3, 1);
            else if (r < 20) tick(1, A_STAT, 32'd0, 1);
            else             tick(0, A_DATA, 0, 1);
            vecCount++;
            if (txd !== expTxd() || IRQ !== expIrq() || bus.Dout !== expStatus()) begin
                errCount++;
                $display("FAIL random cyc %0d: txd=%b IRQ=%b status=%h want txd=%b IRQ=%b status=%h",
                         i, txd, IRQ, bus.Dout, expTxd(), expIrq(), expStatus());
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.WE = 1'b0;
        bus.Addr = '0;
        bus.Din = '0;
        test_reset();
        test_frame();
        test_irq();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
